seq_divider: RTL and testbench



---
 rtl/seq_divider.sv | 135 +++++++++++++
 tb/tb_seq_divider.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/seq_divider.sv
// Multi-cycle restoring divider: one quotient bit per clock, signed or unsigned.
// Divide-by-zero and signed overflow bypass the loop and finish in one cycle.
module seq_divider #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             is_signed,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero,
   output logic [1:0]       dbg_state
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
   localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FIX = 2'd2} state_t;

   state_t           state, state_nxt;
   logic             accept;
   logic [CW-1:0]    counter;
   logic [WIDTH-1:0] q_work;
   logic [WIDTH-1:0] prem;
   logic [WIDTH-1:0] dvs_mag;
   logic             neg_q, neg_r, dbz_pend;

   logic             sign_a, sign_b, is_zero, is_ovf;
   logic [WIDTH-1:0] mag_a, mag_b;
   logic [WIDTH:0]   shifted, diff;
   logic             fit;

   assign sign_a  = is_signed & dividend[WIDTH-1];
   assign sign_b  = is_signed & divisor[WIDTH-1];
   assign mag_a   = sign_a ? -dividend : dividend;
   assign mag_b   = sign_b ? -divisor : divisor;
   assign is_zero = (divisor == '0);
   assign is_ovf  = is_signed && (dividend == MIN_NEG) && (divisor == '1);

   // The WIDTH+1-bit partial remainder only exists in the shifted/trial value;
   // after a kept subtraction it always fits back into WIDTH bits.
   assign shifted = {prem, q_work[WIDTH-1]};
   assign diff    = shifted - {1'b0, dvs_mag};
   assign fit     = ~diff[WIDTH];

   assign busy      = (state != IDLE);
   assign dbg_state = state;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               accept    = 1'b1;
               state_nxt = (is_zero || is_ovf) ? FIX : RUN;
            end
         end
         RUN:     if (counter == LAST) state_nxt = FIX;
         FIX:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         counter     <= '0;
         q_work      <= '0;
         prem        <= '0;
         dvs_mag     <= '0;
         neg_q       <= 1'b0;
         neg_r       <= 1'b0;
         dbz_pend    <= 1'b0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
         done        <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  div_by_zero <= 1'b0;
                  counter     <= '0;
                  dvs_mag     <= mag_b;
                  if (is_zero) begin
                     // Remainder is the raw dividend, so no sign fix-up applies.
                     q_work   <= '1;
                     prem     <= dividend;
                     neg_q    <= 1'b0;
                     neg_r    <= 1'b0;
                     dbz_pend <= 1'b1;
                  end else if (is_ovf) begin
                     q_work   <= MIN_NEG;
                     prem     <= '0;
                     neg_q    <= 1'b0;
                     neg_r    <= 1'b0;
                     dbz_pend <= 1'b0;
                  end else begin
                     q_work   <= mag_a;
                     prem     <= '0;
                     neg_q    <= sign_a ^ sign_b;
                     neg_r    <= sign_a;
                     dbz_pend <= 1'b0;
                  end
               end
            end
            RUN: begin
               prem    <= fit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
               q_work  <= {q_work[WIDTH-2:0], fit};
               counter <= counter + 1'b1;
            end
            FIX: begin
               quotient    <= neg_q ? -q_work : q_work;
               remainder   <= neg_r ? -prem : prem;
               div_by_zero <= dbz_pend;
               done        <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider: an arithmetic reference model feeds a
// scoreboard checked every cycle, and each vector also carries hand-computed results.
module tb_seq_divider;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         start;
   logic         is_signed;
   logic [W-1:0] dividend;
   logic [W-1:0] divisor;
   logic         busy;
   logic         done;
   logic [W-1:0] quotient;
   logic [W-1:0] remainder;
   logic         div_by_zero;
   logic [1:0]   dbg_state;

   seq_divider #(.WIDTH(W)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .start(start),
      .is_signed(is_signed),
      .dividend(dividend),
      .divisor(divisor),
      .busy(busy),
      .done(done),
      .quotient(quotient),
      .remainder(remainder),
      .div_by_zero(div_by_zero),
      .dbg_state(dbg_state)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   // ---------------- scoreboard state ----------------
   int total = 0;
   int bad = 0;
   int inflight = 0;
   int since_start = 0;
   int done_seen = 0;
   int n_ops = 0;

   logic [W-1:0] exp_q[$];
   logic [W-1:0] exp_r_q[$];
   logic [W-1:0] exp_z_q[$];
   logic [W-1:0] exp_lat_q[$];

   logic [W-1:0] last_q, last_r;
   logic         last_z;

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference behaviour straight from the arithmetic definition.
   task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                        output logic [W-1:0] q, output logic [W-1:0] r,
                        output logic z, output int lat);
      int sa, sb;
      sa = a;
      sb = b;
      if (b == 0) begin
         q = '1; r = a; z = 1'b1; lat = 1;
      end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
         q = 32'h8000_0000; r = '0; z = 1'b0; lat = 1;
      end else if (s) begin
         q = sa / sb; r = sa % sb; z = 1'b0; lat = W + 1;
      end else begin
         q = a / b; r = a % b; z = 1'b0; lat = W + 1;
      end
   endtask

   always @(posedge clk) if (inflight != 0) since_start = since_start + 1;

   // ---------------- compare process ----------------
   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         if (done) begin
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL spurious_done: got done=1 expected no done (t=%0t)", $time);
            end else begin
               check("quotient", quotient, exp_q.pop_front());
               check("remainder", remainder, exp_r_q.pop_front());
               check("div_by_zero", W'(div_by_zero), exp_z_q.pop_front());
               check("latency", W'(since_start), exp_lat_q.pop_front());
               check("busy_at_done", W'(busy), 0);
               last_q = quotient;
               last_r = remainder;
               last_z = div_by_zero;
               done_seen++;
            end
            inflight = 0;
         end else if (inflight != 0) begin
            check("busy_in_flight", W'(busy), 1);
         end else begin
            check("busy_idle", W'(busy), 0);
         end
      end
   end

   // ---------------- driver tasks ----------------
   // poke_at >= 0 re-pulses start with other operands that many edges after acceptance.
   task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                        input logic [W-1:0] lit_q, input logic [W-1:0] lit_r,
                        input logic lit_z, input int poke_at);
      logic [W-1:0] mq, mr;
      logic         mz;
      int           mlat, n;
      model(a, b, s, mq, mr, mz, mlat);
      exp_q.push_back(mq);
      exp_r_q.push_back(mr);
      exp_z_q.push_back(W'(mz));
      exp_lat_q.push_back(W'(mlat));
      n_ops++;
      @(posedge clk); #1;
      dividend = a; divisor = b; is_signed = s; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; inflight = 1; since_start = 0;
      if (poke_at == 0) begin
         start = 1'b1; dividend = ~a; divisor = 32'd3; is_signed = ~s;
      end
      n = 0;
      while (inflight != 0 && n < 60) begin
         @(posedge clk); #1;
         start = 1'b0;
         if (inflight != 0 && since_start == poke_at) begin
            start = 1'b1; dividend = ~a; divisor = 32'd3; is_signed = ~s;
         end
         n++;
      end
      start = 1'b0;
      if (n >= 60) begin
         total++;
         bad++;
         $display("FAIL done_timeout: got no done expected done within 60 cycles");
         inflight = 0;
         exp_q.delete(); exp_r_q.delete(); exp_z_q.delete(); exp_lat_q.delete();
      end else begin
         check("literal_quotient", last_q, lit_q);
         check("literal_remainder", last_r, lit_r);
         check("literal_dbz", W'(last_z), W'(lit_z));
      end
   endtask

   task automatic reset_mid_op();
      int n;
      @(posedge clk); #1;
      dividend = 32'hDEAD_BEEF; divisor = 32'h13; is_signed = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; inflight = 1; since_start = 0;
      n = 0;
      while (since_start < 20 && n < 40) begin
         @(posedge clk); #1;
         n++;
      end
      inflight = 0;
      rst_n = 1'b0;
      #1;
      check("abort_busy", W'(busy), 0);
      check("abort_done", W'(done), 0);
      check("abort_quotient", quotient, 0);
      check("abort_remainder", remainder, 0);
      check("abort_dbz", W'(div_by_zero), 0);
      check("abort_state", W'(dbg_state), 0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (40) @(posedge clk);
      #1;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      rst_n = 1'b0; start = 1'b0; is_signed = 1'b0; dividend = '0; divisor = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_busy", W'(busy), 0);
      check("reset_done", W'(done), 0);
      check("reset_quotient", quotient, 0);
      check("reset_remainder", remainder, 0);
      check("reset_dbz", W'(div_by_zero), 0);
      check("reset_state", W'(dbg_state), 0);
      @(posedge clk); #1 rst_n = 1'b1;

      do_op(32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0, -1);
      do_op(-32'sd100, 32'd7, 1'b1, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0, -1);
      do_op(32'd100, -32'sd7, 1'b1, 32'hFFFF_FFF2, 32'd2, 1'b0, -1);
      do_op(-32'sd100, -32'sd7, 1'b1, 32'd14, 32'hFFFF_FFFE, 1'b0, -1);
      do_op(32'h1234_5678, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'h1234_5678, 1'b1, 0);
      do_op(32'h1234_5678, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'h1234_5678, 1'b1, -1);
      do_op(32'h8000_0001, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'h8000_0001, 1'b1, -1);
      do_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0, 1'b0, 0);
      do_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'd0, 32'h8000_0000, 1'b0, -1);
      do_op(32'hFFFF_FFFF, 32'd1, 1'b0, 32'hFFFF_FFFF, 32'd0, 1'b0, 10);
      do_op(32'd7, 32'd9, 1'b0, 32'd0, 32'd7, 1'b0, 32);
      do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'd1, 32'd0, 1'b0, -1);
      do_op(32'h8000_0000, 32'd2, 1'b1, 32'hC000_0000, 32'd0, 1'b0, -1);
      do_op(32'h8000_0000, 32'd1, 1'b1, 32'h8000_0000, 32'd0, 1'b0, -1);
      do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'd1, 32'd0, 1'b0, -1);

      reset_mid_op();
      do_op(32'd9, 32'd3, 1'b0, 32'd3, 32'd0, 1'b0, -1);

      repeat (40) @(posedge clk);
      #1;
      check("done_count", W'(done_seen), W'(n_ops));
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
